// File: rtl/vin_to_axi4s_pkg.sv
// Shared types for the video-in capture stage: FSM encoding and FIFO entry layout.
// FIFO entry is {user, last, data}, DATA_WIDTH+2 bits wide.
package vin_to_axi4s_pkg;

   typedef enum logic {
      ST_WAIT  = 1'b0,
      ST_FRAME = 1'b1
   } state_t;

   function automatic int entry_width(input int data_width);
      return data_width + 2;
   endfunction

endpackage

// File: rtl/vin_to_axi4s_fifo.sv
// Synchronous first-word-fall-through FIFO, depth 2**PTR_WIDTH; head visible while not empty.
// A push into a full FIFO is accepted only alongside a pop; refused pushes are ignored.
module vin_to_axi4s_fifo #(
   parameter int WIDTH     = 26,
   parameter int PTR_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_dat,
   input  logic                 pop,
   output logic [WIDTH-1:0]     pop_dat,
   output logic [PTR_WIDTH:0]   count,
   output logic                 full,
   output logic                 empty
);
   localparam int DEPTH = 1 << PTR_WIDTH;
   localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(DEPTH);

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]   count_q, count_d;
   logic                 wr_en, rd_en;

   always_comb begin
      rd_en    = pop & (count_q != '0);
      wr_en    = push & ((count_q != DEPTH_C) | rd_en);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_dat;
   end

   assign pop_dat = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);

endmodule

// File: rtl/vin_to_axi4s.sv
// DE-qualified pixel bus to AXI4-Stream video; pixel in cycle N appears on the stream in N+2.
// Back-pressure is absorbed by the FIFO; a refused push drops the rest of the frame until the next vsync.
module vin_to_axi4s
   import vin_to_axi4s_pkg::*;
#(
   parameter int DATA_WIDTH     = 24,
   parameter int FIFO_PTR_WIDTH = 4,
   parameter int H_WIDTH        = 12,
   parameter int V_WIDTH        = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  overflow_clear,
   input  logic                  in_vsync,
   input  logic                  in_de,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  m_axi4s_tuser,
   output logic                  m_axi4s_tlast,
   output logic [DATA_WIDTH-1:0] m_axi4s_tdata,
   output logic                  m_axi4s_tvalid,
   input  logic                  m_axi4s_tready,
   output logic                  busy,
   output logic                  overflow,
   output logic [H_WIDTH-1:0]    frame_width,
   output logic [V_WIDTH-1:0]    frame_height
);
   localparam int EW = entry_width(DATA_WIDTH);
   localparam logic [H_WIDTH-1:0] H_ONE = 1;
   localparam logic [V_WIDTH-1:0] V_ONE = 1;

   state_t                  state_q, state_d;
   logic                    vsync_q;
   logic                    sof_pending_q, sof_pending_d;
   logic                    stg_valid_q, stg_valid_d;
   logic                    stg_user_q, stg_user_d;
   logic [DATA_WIDTH-1:0]   stg_data_q, stg_data_d;
   logic [H_WIDTH-1:0]      pix_cnt_q, pix_cnt_d;
   logic [V_WIDTH-1:0]      line_cnt_q, line_cnt_d;
   logic [H_WIDTH-1:0]      frame_width_q, frame_width_d;
   logic [V_WIDTH-1:0]      frame_height_q, frame_height_d;
   logic                    overflow_q, overflow_d;

   logic                    vs_rise, de_cap, push_last, push_ok, ovf_evt, line_end;
   logic                    fifo_pop, fifo_full, fifo_empty;
   logic [EW-1:0]           fifo_rdat;
   logic [FIFO_PTR_WIDTH:0] fifo_count;

   always_comb begin
      vs_rise   = in_vsync & ~vsync_q;
      de_cap    = in_de & (state_q == ST_FRAME);
      // The staged pixel closes the line unless another captured pixel follows it.
      push_last = ~de_cap;
      fifo_pop  = m_axi4s_tready & ~fifo_empty;
      push_ok   = stg_valid_q & (~fifo_full | fifo_pop);
      ovf_evt   = stg_valid_q & ~push_ok;
      line_end  = push_ok & push_last;

      state_d = state_q;
      if (ovf_evt) state_d = ST_WAIT;
      if (vs_rise) state_d = enable ? ST_FRAME : ST_WAIT;

      stg_valid_d = de_cap & ~ovf_evt;
      stg_user_d  = sof_pending_q;
      stg_data_d  = in_data;

      sof_pending_d = sof_pending_q;
      if (stg_valid_d) sof_pending_d = 1'b0;
      if (vs_rise)     sof_pending_d = 1'b1;

      pix_cnt_d     = pix_cnt_q;
      frame_width_d = frame_width_q;
      if (ovf_evt || line_end) pix_cnt_d = '0;
      else if (push_ok && !(&pix_cnt_q)) pix_cnt_d = pix_cnt_q + H_ONE;
      if (line_end) frame_width_d = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + H_ONE;

      line_cnt_d     = line_cnt_q;
      frame_height_d = frame_height_q;
      if (line_end && !(&line_cnt_q)) line_cnt_d = line_cnt_q + V_ONE;
      if (vs_rise) begin
         // A line closing on the vsync edge still belongs to the frame being measured.
         frame_height_d = line_cnt_d;
         line_cnt_d     = '0;
      end

      overflow_d = overflow_q;
      if (overflow_clear) overflow_d = 1'b0;
      if (ovf_evt)        overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_WAIT;
         vsync_q        <= 1'b0;
         sof_pending_q  <= 1'b0;
         stg_valid_q    <= 1'b0;
         stg_user_q     <= 1'b0;
         stg_data_q     <= '0;
         pix_cnt_q      <= '0;
         line_cnt_q     <= '0;
         frame_width_q  <= '0;
         frame_height_q <= '0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         vsync_q        <= in_vsync;
         sof_pending_q  <= sof_pending_d;
         stg_valid_q    <= stg_valid_d;
         stg_user_q     <= stg_user_d;
         stg_data_q     <= stg_data_d;
         pix_cnt_q      <= pix_cnt_d;
         line_cnt_q     <= line_cnt_d;
         frame_width_q  <= frame_width_d;
         frame_height_q <= frame_height_d;
         overflow_q     <= overflow_d;
      end
   end

   vin_to_axi4s_fifo #(
      .WIDTH     (EW),
      .PTR_WIDTH (FIFO_PTR_WIDTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (stg_valid_q),
      .push_dat ({stg_user_q, push_last, stg_data_q}),
      .pop      (fifo_pop),
      .pop_dat  (fifo_rdat),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata} = fifo_empty ? '0 : fifo_rdat;
   assign m_axi4s_tvalid = ~fifo_empty;
   assign busy           = (state_q == ST_FRAME);
   assign overflow       = overflow_q;
   assign frame_width    = frame_width_q;
   assign frame_height   = frame_height_q;

endmodule
